// File: rtl/amiga_kbd_pkg.sv
// Shared types and constants for the Amiga keyboard-side KCLK/KDAT transmitter.
package amiga_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CLK_LOW,
    ST_CLK_HIGH,
    ST_WAIT_HS,
    ST_HS_END,
    ST_RESYNC,
    ST_HARD_RST
  } kbd_state_t;

  // Which byte the sequencer has in flight.
  typedef enum logic [1:0] {
    SEL_KEY,
    SEL_LOST,
    SEL_INIT,
    SEL_TERM
  } kbd_sel_t;

  localparam logic [7:0] KBD_LOST_SYNC  = 8'hF9;
  localparam logic [7:0] KBD_INIT_PWRUP = 8'hFD;
  localparam logic [7:0] KBD_TERM_PWRUP = 8'hFE;

  // Wire order is key bits 6..0 followed by the up/down flag.
  function automatic logic [7:0] kbd_wire_byte(input logic [7:0] code);
    return {code[6:0], code[7]};
  endfunction

endpackage

// File: rtl/amiga_kbd_hs_detect.sv
// KDAT handshake detector: 2-flop synchroniser plus a consecutive-low counter.
module amiga_kbd_hs_detect #(
  parameter int hs_min_cycles = 29
) (
  input  logic clk,
  input  logic rst,
  input  logic kdat_in,
  input  logic arm,
  output logic hs_seen,
  output logic line_high
);

  localparam int LW = $clog2(hs_min_cycles + 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(hs_min_cycles);

  logic          sync1;
  logic          sync2;
  logic [LW-1:0] low_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      low_cnt <= '0;
    end else begin
      sync1 <= kdat_in;
      sync2 <= sync1;
      // Lows seen while disarmed (our own data bits) never count.
      if (!arm || sync2) begin
        low_cnt <= '0;
      end else if (low_cnt != LOW_MAX) begin
        low_cnt <= low_cnt + LW'(1);
      end
    end
  end

  assign hs_seen   = (low_cnt == LOW_MAX);
  assign line_high = sync2;

endmodule

// File: rtl/amiga_keyboard_tx.sv
// Amiga keyboard transmitter: serialises keycodes on open-drain KCLK/KDAT with
// handshake wait, lost-sync recovery, power-up stream and Ctrl-Amiga-Amiga reset.
module amiga_keyboard_tx
  import amiga_kbd_pkg::*;
#(
  parameter int bit_cycles        = 573,
  parameter int hs_min_cycles     = 29,
  parameter int hs_timeout_cycles = 4095000,
  parameter int hard_reset_cycles = 14318180
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       reset_req,
  input  logic       KDAT_IN,
  output logic       KCLK_OE,
  output logic       KDAT_OE,
  output logic       sync_lost,
  output kbd_state_t fsm_state
);

  localparam int MAX_A = (bit_cycles > hs_min_cycles) ? bit_cycles : hs_min_cycles;
  localparam int MAX_B = (hs_timeout_cycles > hard_reset_cycles) ? hs_timeout_cycles
                                                                 : hard_reset_cycles;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 2;

  localparam logic [CW-1:0] BIT_LAST   = CW'(bit_cycles - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(hs_timeout_cycles - 1);
  localparam logic [CW-1:0] HR_LAST    = CW'(hard_reset_cycles - 1);
  localparam logic [CW-1:0] SYNC_FLUSH = CW'(2);

  kbd_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic [7:0]    hold, hold_d;
  kbd_sel_t      sel, sel_d;
  logic          resyncing, resyncing_d;
  logic          pwrup, pwrup_d;
  logic          lost_d, kclk_d, kdat_d, ready_d;
  logic          go_next;
  kbd_sel_t      nxt_sel;
  logic          phase_done;
  logic          arm, hs_seen, line_high;

  function automatic logic [7:0] sel_byte(input kbd_sel_t s, input logic [7:0] h);
    case (s)
      SEL_LOST: return kbd_wire_byte(KBD_LOST_SYNC);
      SEL_INIT: return kbd_wire_byte(KBD_INIT_PWRUP);
      SEL_TERM: return kbd_wire_byte(KBD_TERM_PWRUP);
      default:  return kbd_wire_byte(h);
    endcase
  endfunction

  // The synchroniser still holds our last driven bit for two cycles after release.
  assign arm = (state == ST_WAIT_HS) && (cnt >= SYNC_FLUSH);

  amiga_kbd_hs_detect #(
    .hs_min_cycles(hs_min_cycles)
  ) u_hs_detect (
    .clk      (CLK),
    .rst      (RST),
    .kdat_in  (KDAT_IN),
    .arm      (arm),
    .hs_seen  (hs_seen),
    .line_high(line_high)
  );

  assign phase_done = (cnt == BIT_LAST);
  assign fsm_state  = state;

  // key_code transfers on a cycle where key_valid and key_ready are both high;
  // key_ready is high only in IDLE and the upstream holds the key otherwise.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt + CW'(1);
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    hold_d      = hold;
    sel_d       = sel;
    resyncing_d = resyncing;
    pwrup_d     = pwrup;
    lost_d      = 1'b0;
    go_next     = 1'b0;
    nxt_sel     = sel;

    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (reset_req) begin
          state_d = ST_HARD_RST;
        end else if (key_valid) begin
          hold_d    = key_code;
          sel_d     = SEL_KEY;
          shreg_d   = kbd_wire_byte(key_code);
          bit_idx_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP, ST_RESYNC: begin
        if (phase_done) begin
          state_d = ST_CLK_LOW;
          cnt_d   = '0;
        end
      end
      ST_CLK_LOW: begin
        if (phase_done) begin
          state_d = ST_CLK_HIGH;
          cnt_d   = '0;
        end
      end
      ST_CLK_HIGH: begin
        if (phase_done) begin
          cnt_d = '0;
          if (resyncing || bit_idx == 3'd7) begin
            state_d = ST_WAIT_HS;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {shreg[6:0], 1'b0};
            state_d   = ST_SETUP;
          end
        end
      end
      ST_WAIT_HS: begin
        // Timeout wins over a handshake detected on the same cycle.
        if (cnt == TO_LAST) begin
          lost_d      = 1'b1;
          resyncing_d = 1'b1;
          state_d     = ST_RESYNC;
          cnt_d       = '0;
        end else if (hs_seen) begin
          state_d = ST_HS_END;
        end
      end
      ST_HS_END: begin
        cnt_d = '0;
        if (line_high) begin
          if (resyncing) begin
            resyncing_d = 1'b0;
            go_next     = 1'b1;
            nxt_sel     = pwrup ? SEL_INIT : SEL_LOST;
          end else begin
            case (sel)
              SEL_LOST: begin go_next = 1'b1; nxt_sel = SEL_KEY;  end
              SEL_INIT: begin go_next = 1'b1; nxt_sel = SEL_TERM; end
              SEL_TERM: begin pwrup_d = 1'b0; state_d = ST_IDLE; end
              default:  state_d = ST_IDLE;
            endcase
          end
        end
      end
      ST_HARD_RST: begin
        cnt_d = (cnt == HR_LAST) ? cnt : cnt + CW'(1);
        if (cnt == HR_LAST && !reset_req) begin
          state_d     = ST_RESYNC;
          cnt_d       = '0;
          pwrup_d     = 1'b1;
          resyncing_d = 1'b1;
        end
      end
      default: state_d = ST_RESYNC;
    endcase

    if (go_next) begin
      sel_d     = nxt_sel;
      shreg_d   = sel_byte(nxt_sel, hold);
      bit_idx_d = '0;
      state_d   = ST_SETUP;
    end

    // Line drives are registered from the next state so they change with it.
    kclk_d  = (state_d == ST_CLK_LOW) || (state_d == ST_HARD_RST);
    kdat_d  = (state_d == ST_RESYNC) ||
              (((state_d == ST_SETUP) || (state_d == ST_CLK_LOW) || (state_d == ST_CLK_HIGH)) &&
               (resyncing_d || shreg_d[7]));
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_RESYNC;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      hold      <= '0;
      sel       <= SEL_INIT;
      resyncing <= 1'b1;
      pwrup     <= 1'b1;
      KCLK_OE   <= 1'b0;
      KDAT_OE   <= 1'b0;
      key_ready <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      hold      <= hold_d;
      sel       <= sel_d;
      resyncing <= resyncing_d;
      pwrup     <= pwrup_d;
      KCLK_OE   <= kclk_d;
      KDAT_OE   <= kdat_d;
      key_ready <= ready_d;
      sync_lost <= lost_d;
    end
  end

endmodule

// File: tb/tb_amiga_keyboard_tx.sv
// Directed bench for amiga_keyboard_tx with a wired-AND KDAT line and a host handshake driver.
module tb_amiga_keyboard_tx;
  import amiga_kbd_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] key_code = 8'h00;
  logic       key_valid = 1'b0;
  logic       reset_req = 1'b0;
  logic       host_low = 1'b0;
  logic       key_ready, KCLK_OE, KDAT_OE, sync_lost, kdat_line;
  kbd_state_t fsm_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lost_cnt = 0;

  assign kdat_line = ~(host_low | KDAT_OE);

  amiga_keyboard_tx #(
    .bit_cycles       (4),
    .hs_min_cycles    (2),
    .hs_timeout_cycles(200),
    .hard_reset_cycles(50)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .reset_req(reset_req),
    .KDAT_IN  (kdat_line),
    .KCLK_OE  (KCLK_OE),
    .KDAT_OE  (KDAT_OE),
    .sync_lost(sync_lost),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (sync_lost === 1'b1) lost_cnt <= lost_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Collects KDAT_OE on each falling KCLK_OE edge, then waits for KDAT release.
  task automatic recv_bits(input int nbits, output logic [7:0] bits,
                           output int fall_cyc, output int rel_cyc);
    int   got = 0;
    int   guard = 0;
    logic prev;
    bits = 8'h00;
    fall_cyc = -1;
    prev = KCLK_OE;
    while (got < nbits && guard < 2000) begin
      @(negedge CLK);
      guard++;
      if (prev === 1'b1 && KCLK_OE === 1'b0) begin
        bits = {bits[6:0], KDAT_OE};
        got++;
        fall_cyc = cyc;
      end
      prev = KCLK_OE;
    end
    while (KDAT_OE !== 1'b0 && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    rel_cyc = cyc;
    check("recv_bit_count", got, nbits);
  endtask

  task automatic handshake(input int dly, input int len);
    repeat (dly) @(negedge CLK);
    host_low = 1'b1;
    repeat (len) @(negedge CLK);
    host_low = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (key_ready !== 1'b1 && g < 300) begin
      @(negedge CLK);
      g++;
    end
    check(tag, key_ready, 1);
  endtask

  task automatic wait_lost(output int at);
    int g = 0;
    at = -1;
    while (g < 400) begin
      @(negedge CLK);
      g++;
      if (sync_lost === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check("sync_lost_seen", (at >= 0), 1);
  endtask

  task automatic send_key(input logic [7:0] code, output int acc);
    wait_ready("ready_before_key");
    key_code  = code;
    key_valid = 1'b1;
    @(negedge CLK);
    acc       = cyc;
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic powerup(input string tag);
    logic [7:0] b;
    int f, r;
    recv_bits(1, b, f, r);
    check({tag, "_resync_bit"}, b[0], 1);
    handshake(10, 6);
    recv_bits(8, b, f, r);
    check({tag, "_fd_wire"}, b, 8'hFB);
    handshake(10, 6);
    recv_bits(8, b, f, r);
    check({tag, "_fe_wire"}, b, 8'hFD);
    handshake(10, 6);
    wait_ready({tag, "_ready"});
    check({tag, "_idle"}, fsm_state, ST_IDLE);
  endtask

  // driver / scoreboard sequence
  initial begin
    logic [7:0] b;
    int acc, f, rel, rel2, rel3, sl, hi;
    logic done;

    repeat (3) @(negedge CLK);
    check("rst_kclk", KCLK_OE, 0);
    check("rst_kdat", KDAT_OE, 0);
    check("rst_ready", key_ready, 0);
    check("rst_lost", sync_lost, 0);
    RST = 1'b0;

    powerup("pwr");
    check("pwr_no_timeout", lost_cnt, 0);

    // Esc down: 0x45 -> wire 0x8A
    send_key(8'h45, acc);
    check("esc_bit6_valid", KDAT_OE, 1);
    check("esc_ready_low", key_ready, 0);
    recv_bits(8, b, f, rel);
    check("esc_wire", b, 8'h8A);
    check("esc_last_fall_cyc", f - acc, 92);
    handshake(10, 6);

    // Esc up: 0xC5 -> wire 0x8B; then let the handshake time out twice
    send_key(8'hC5, acc);
    recv_bits(8, b, f, rel);
    check("up_wire", b, 8'h8B);
    check("up_last_bit", b[0], 1);
    check("up_release_cyc", rel - acc, 96);
    wait_lost(sl);
    check("timeout_cyc", sl - rel, 200);
    @(negedge CLK);
    check("lost_one_cycle", sync_lost, 0);
    recv_bits(1, b, f, rel2);
    check("resync1_bit", b[0], 1);
    check("resync1_period", rel2 - rel, 212);
    wait_lost(sl);
    recv_bits(1, b, f, rel3);
    check("resync2_bit", b[0], 1);
    check("resync2_period", rel3 - rel2, 212);
    handshake(10, 6);
    recv_bits(8, b, f, rel);
    check("lost_sync_wire", b, 8'hF3);
    handshake(10, 6);
    recv_bits(8, b, f, rel);
    check("retransmit_wire", b, 8'h8B);
    handshake(10, 6);
    wait_ready("after_resync_ready");
    check("lost_count", lost_cnt, 2);

    // Glitch rejection: 0x12 -> wire 0x24
    send_key(8'h12, acc);
    recv_bits(8, b, f, rel);
    check("glitch_key_wire", b, 8'h24);
    handshake(12, 1);
    repeat (20) @(negedge CLK);
    check("glitch_rejected", key_ready, 0);
    handshake(0, 3);
    wait_ready("glitch_hs_ready");
    check("glitch_no_timeout", lost_cnt, 2);

    // Hard reset held 80 cycles, offered together with a key
    @(negedge CLK);
    reset_req = 1'b1;
    key_code  = 8'h33;
    key_valid = 1'b1;
    hi = 0;
    done = 1'b0;
    for (int i = 1; i <= 300 && !done; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        check("hr_priority_kdat", KDAT_OE, 0);
        key_valid = 1'b0;
        key_code  = 8'h00;
      end
      if (KCLK_OE === 1'b1) hi++;
      else if (hi > 0) done = 1'b1;
      if (i == 80) reset_req = 1'b0;
    end
    check("hr_kclk_len", hi, 80);
    powerup("hr");

    // RST mid-byte
    send_key(8'h45, acc);
    repeat (5) @(negedge CLK);
    check("mid_kclk_low_phase", KCLK_OE, 1);
    check("mid_kdat_bit", KDAT_OE, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_kclk", KCLK_OE, 0);
    check("midrst_kdat", KDAT_OE, 0);
    check("midrst_ready", key_ready, 0);
    check("midrst_lost", sync_lost, 0);
    RST = 1'b0;
    recv_bits(1, b, f, rel);
    check("midrst_resync_bit", b[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
